// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, single in-flight ROM read, small decode buffer.
// Optional fetch range check enabled by defining FETCH_BOUND_CHECK_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          BUF_DEPTH     = 2,
    parameter int          ROM_ADDR_BITS = 13
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        rom_en_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        fault_o,
    output logic [31:0] fault_pc_o
);

    localparam int IW = $clog2(BUF_DEPTH);
    localparam int CW = IW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(BUF_DEPTH);

`ifdef FETCH_BOUND_CHECK_EN
    localparam bit BOUND_EN = 1'b1;
`else
    localparam bit BOUND_EN = 1'b0;
`endif

    typedef enum logic {
        RUN,
        FAULT
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] inflight_pc;
    logic [31:0] fault_pc;
    logic        inflight;
    logic        kill;

    logic [31:0] fifo_data [BUF_DEPTH];
    logic [31:0] fifo_pc   [BUF_DEPTH];
    logic [IW-1:0] head;
    logic [IW-1:0] tail;
    logic [CW-1:0] count;

    logic        pop;
    logic        push;
    logic [CW:0] occ;
    logic        room;
    logic        pc_oor;
    logic        tgt_bad;
    logic        issue;

    // Issue decision: room left after counting the in-flight word and this cycle's pop
    always_comb begin
        pop     = instr_valid_o & instr_ready_i;
        push    = inflight & ~kill & ~redirect_i;
        occ     = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
        room    = occ < DEPTH_W;
        pc_oor  = BOUND_EN && ((pc >> ROM_ADDR_BITS) != 32'd0);
        tgt_bad = (redirect_pc_i[1:0] != 2'b00) ||
                  (BOUND_EN && ((redirect_pc_i >> ROM_ADDR_BITS) != 32'd0));
        issue   = reset_n & ~redirect_i & (state == RUN) & room & ~pc_oor;
    end

    assign rom_en_o      = issue;
    assign rom_addr_o    = pc;
    assign instr_valid_o = count != '0;
    assign instr_o       = fifo_data[head];
    assign instr_pc_o    = fifo_pc[head];
    assign fault_o       = state == FAULT;
    assign fault_pc_o    = fault_pc;

    // Control FSM: PC, in-flight tracking, buffer pointers, fault capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            kill        <= 1'b0;
            fault_pc    <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            kill <= redirect_i;
            if (redirect_i) begin
                pc       <= redirect_pc_i;
                inflight <= 1'b0;
                count    <= '0;
                head     <= '0;
                tail     <= '0;
                if (tgt_bad) begin
                    state    <= FAULT;
                    fault_pc <= redirect_pc_i;
                end else begin
                    state <= RUN;
                end
            end else begin
                inflight <= issue;
                if (issue) begin
                    pc          <= pc + 32'd4;
                    inflight_pc <= pc;
                end
                if (push) tail <= tail + IW'(1);
                if (pop)  head <= head + IW'(1);
                count <= count + CW'(push) - CW'(pop);
                if (state == RUN && pc_oor) begin
                    state    <= FAULT;
                    fault_pc <= pc;
                end
            end
        end
    end

    // Buffer storage: returned ROM word and its PC written at the tail
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (push) begin
            fifo_data[tail] <= rom_data_i;
            fifo_pc[tail]   <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a one-cycle ROM model.
// Range-check scenario follows FETCH_BOUND_CHECK_EN.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        rom_en_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b1;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        fault_o;
    logic [31:0] fault_pc_o;

    int passed = 0;
    int total  = 0;

    logic [31:0] rom_q = '0;

    instr_fetch_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rom_en_o      (rom_en_o),
        .rom_addr_o    (rom_addr_o),
        .rom_data_i    (rom_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .fault_o       (fault_o),
        .fault_pc_o    (fault_pc_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] romf(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    always @(posedge clk) if (rom_en_o) rom_q <= romf(rom_addr_o);
    assign rom_data_i = rom_q;

    task automatic test_reset();
        #1 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if ({rom_en_o, rom_addr_o, instr_valid_o, fault_o} !== {1'b0, 32'h0, 1'b0, 1'b0})
            $display("FAIL reset_ctrl: got en=%b addr=%h v=%b f=%b want 0/0/0/0",
                     rom_en_o, rom_addr_o, instr_valid_o, fault_o);
        else passed++;
        total++;
        if ({instr_o, instr_pc_o, fault_pc_o} !== 96'h0)
            $display("FAIL reset_data: got instr=%h pc=%h fpc=%h want 0", instr_o, instr_pc_o, fault_pc_o);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 6; k++) begin
            total++;
            if ({rom_en_o, rom_addr_o} !== {1'b1, 32'(4 * k)})
                $display("FAIL seq_req[%0d]: got en=%b addr=%h want 1/%h", k, rom_en_o, rom_addr_o, 32'(4 * k));
            else passed++;
            total++;
            if (instr_valid_o !== (k >= 2))
                $display("FAIL seq_valid[%0d]: got %b want %b", k, instr_valid_o, k >= 2);
            else passed++;
            if (k >= 2) begin
                total++;
                if ({instr_pc_o, instr_o} !== {32'(4 * (k - 2)), romf(32'(4 * (k - 2)))})
                    $display("FAIL seq_data[%0d]: got pc=%h instr=%h want pc=%h", k, instr_pc_o, instr_o, 32'(4 * (k - 2)));
                else passed++;
            end
            if (k < 5) begin
                @(negedge clk);
                #1;
            end
        end
    endtask

    task automatic test_stall();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            instr_ready_i = 1'b0;
            #1;
            total++;
            if ({rom_en_o, instr_valid_o, instr_pc_o} !== {1'b0, 1'b1, 32'h10})
                $display("FAIL stall_hold[%0d]: got en=%b v=%b pc=%h want 0/1/10", c, rom_en_o, instr_valid_o, instr_pc_o);
            else passed++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            instr_ready_i = 1'b1;
            #1;
            total++;
            if ({rom_en_o, rom_addr_o} !== {1'b1, 32'h18 + 32'(4 * i)})
                $display("FAIL resume_req[%0d]: got en=%b addr=%h want 1/%h", i, rom_en_o, rom_addr_o, 32'h18 + 32'(4 * i));
            else passed++;
            total++;
            if ({instr_valid_o, instr_pc_o, instr_o} !== {1'b1, 32'h10 + 32'(4 * i), romf(32'h10 + 32'(4 * i))})
                $display("FAIL resume_data[%0d]: got v=%b pc=%h instr=%h want pc=%h", i, instr_valid_o, instr_pc_o, instr_o, 32'h10 + 32'(4 * i));
            else passed++;
        end
    endtask

    task automatic test_redirect_kill();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h100;
        #1;
        total++;
        if ({rom_en_o, instr_valid_o, instr_pc_o} !== {1'b0, 1'b1, 32'h4})
            $display("FAIL redir_cycle: got en=%b v=%b pc=%h want 0/1/4", rom_en_o, instr_valid_o, instr_pc_o);
        else passed++;
        @(negedge clk);
        redirect_i = 1'b0;
        #1;
        total++;
        if ({rom_en_o, rom_addr_o, instr_valid_o} !== {1'b1, 32'h100, 1'b0})
            $display("FAIL redir_r1: got en=%b addr=%h v=%b want 1/100/0", rom_en_o, rom_addr_o, instr_valid_o);
        else passed++;
        @(negedge clk);
        #1;
        total++;
        if ({rom_addr_o, instr_valid_o} !== {32'h104, 1'b0})
            $display("FAIL redir_r2: got addr=%h v=%b want 104/0", rom_addr_o, instr_valid_o);
        else passed++;
        @(negedge clk);
        #1;
        total++;
        if ({instr_valid_o, instr_pc_o, instr_o} !== {1'b1, 32'h100, romf(32'h100)})
            $display("FAIL redir_first: got v=%b pc=%h instr=%h want 1/100/%h", instr_valid_o, instr_pc_o, instr_o, romf(32'h100));
        else passed++;
    endtask

    task automatic test_fault();
        @(negedge clk);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h102;
        #1;
        total++;
        if (rom_en_o !== 1'b0)
            $display("FAIL mis_cycle: got en=%b want 0", rom_en_o);
        else passed++;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            redirect_i = 1'b0;
            #1;
            total++;
            if ({fault_o, fault_pc_o, rom_en_o, instr_valid_o} !== {1'b1, 32'h102, 1'b0, 1'b0})
                $display("FAIL mis_fault[%0d]: got f=%b fpc=%h en=%b v=%b want 1/102/0/0", c, fault_o, fault_pc_o, rom_en_o, instr_valid_o);
            else passed++;
        end
        @(negedge clk);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h200;
        #1;
        total++;
        if ({fault_o, rom_en_o} !== 2'b10)
            $display("FAIL clr_cycle: got f=%b en=%b want 1/0", fault_o, rom_en_o);
        else passed++;
        @(negedge clk);
        redirect_i = 1'b0;
        #1;
        total++;
        if ({fault_o, rom_en_o, rom_addr_o} !== {1'b0, 1'b1, 32'h200})
            $display("FAIL clr_resume: got f=%b en=%b addr=%h want 0/1/200", fault_o, rom_en_o, rom_addr_o);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if ({instr_valid_o, instr_pc_o, instr_o} !== {1'b1, 32'h200, romf(32'h200)})
            $display("FAIL clr_first: got v=%b pc=%h instr=%h want 1/200", instr_valid_o, instr_pc_o, instr_o);
        else passed++;
    endtask

    task automatic test_bound();
        @(negedge clk);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h1FF8;
        @(negedge clk);
        redirect_i = 1'b0;
        #1;
        total++;
        if ({rom_en_o, rom_addr_o} !== {1'b1, 32'h1FF8})
            $display("FAIL bnd_req0: got en=%b addr=%h want 1/1ff8", rom_en_o, rom_addr_o);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        #1;
`ifdef FETCH_BOUND_CHECK_EN
        total++;
        if ({rom_en_o, instr_pc_o, fault_o} !== {1'b0, 32'h1FF8, 1'b0})
            $display("FAIL bnd_stop: got en=%b pc=%h f=%b want 0/1ff8/0", rom_en_o, instr_pc_o, fault_o);
        else passed++;
        @(negedge clk);
        #1;
        total++;
        if ({instr_valid_o, instr_pc_o, fault_o, fault_pc_o, rom_en_o} !== {1'b1, 32'h1FFC, 1'b1, 32'h2000, 1'b0})
            $display("FAIL bnd_fault: got v=%b pc=%h f=%b fpc=%h en=%b want 1/1ffc/1/2000/0",
                     instr_valid_o, instr_pc_o, fault_o, fault_pc_o, rom_en_o);
        else passed++;
        @(negedge clk);
        #1;
        total++;
        if ({instr_valid_o, fault_o, rom_en_o} !== 3'b010)
            $display("FAIL bnd_drain: got v=%b f=%b en=%b want 0/1/0", instr_valid_o, fault_o, rom_en_o);
        else passed++;
`else
        total++;
        if ({rom_en_o, rom_addr_o, instr_pc_o} !== {1'b1, 32'h2000, 32'h1FF8})
            $display("FAIL nobnd_req: got en=%b addr=%h pc=%h want 1/2000/1ff8", rom_en_o, rom_addr_o, instr_pc_o);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if ({instr_valid_o, instr_pc_o, fault_o} !== {1'b1, 32'h2000, 1'b0})
            $display("FAIL nobnd_data: got v=%b pc=%h f=%b want 1/2000/0", instr_valid_o, instr_pc_o, fault_o);
        else passed++;
`endif
        @(negedge clk);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0;
        @(negedge clk);
        redirect_i = 1'b0;
        #1;
        total++;
        if ({fault_o, rom_en_o, rom_addr_o} !== {1'b0, 1'b1, 32'h0})
            $display("FAIL bnd_clear: got f=%b en=%b addr=%h want 0/1/0", fault_o, rom_en_o, rom_addr_o);
        else passed++;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({rom_en_o, rom_addr_o, instr_valid_o, instr_o, instr_pc_o, fault_o, fault_pc_o} !== {1'b0, 32'h0, 1'b0, 96'h0, 1'b0, 32'h0})
            $display("FAIL async_rst: got en=%b addr=%h v=%b instr=%h pc=%h f=%b",
                     rom_en_o, rom_addr_o, instr_valid_o, instr_o, instr_pc_o, fault_o);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        total++;
        if ({rom_en_o, rom_addr_o, instr_valid_o} !== {1'b1, 32'h0, 1'b0})
            $display("FAIL async_restart: got en=%b addr=%h v=%b want 1/0/0", rom_en_o, rom_addr_o, instr_valid_o);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if ({instr_valid_o, instr_pc_o, instr_o} !== {1'b1, 32'h0, romf(32'h0)})
            $display("FAIL async_first: got v=%b pc=%h instr=%h want 1/0/%h", instr_valid_o, instr_pc_o, instr_o, romf(32'h0));
        else passed++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_kill();
        test_fault();
        test_bound();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
